// File: rtl/result_bank.sv
// Result bank: DEPTH x WIDTH indexed store with valid bits, random reads,
// and a sequential drain of valid entries over a valid/ready handshake.
module result_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_enable,
    input  logic [AW-1:0]    in_sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    out_sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             clear_data,
    input  logic             drain_start,
    output logic             drain_valid,
    input  logic             drain_ready,
    output logic [WIDTH-1:0] drain_data,
    output logic [AW-1:0]    drain_idx,
    output logic             drain_busy,
    output logic [AW:0]      count,
    output logic             wr_drop
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_e;

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW-1:0] P_ONE   = AW'(1);
    localparam logic [AW:0]   C_ONE   = (AW+1)'(1);

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [WIDTH-1:0]  data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [AW:0]       count_q, count_d;
    logic              wr_drop_q, wr_drop_d;

    logic in_ok;
    logic out_ok;
    logic cur_valid;
    logic draining;
    logic advance;

    assign in_ok     = ({1'b0, in_sel} < DEPTH_W);
    assign out_ok    = ({1'b0, out_sel} < DEPTH_W);
    assign draining  = (state_q == DRAIN);
    assign cur_valid = valid_q[ptr_q];
    // Invalid slots are skipped unconditionally; valid ones wait for ready.
    assign advance   = draining && (!cur_valid || drain_ready);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        count_d   = count_q;
        wr_drop_d = 1'b0;
        if (clear_data) begin
            state_d   = IDLE;
            ptr_d     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            valid_d   = '0;
            count_d   = '0;
            wr_drop_d = w_enable;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (drain_start) begin
                        state_d   = DRAIN;
                        ptr_d     = '0;
                        wr_drop_d = w_enable;
                    end else if (w_enable) begin
                        if (in_ok) begin
                            data_d[in_sel]  = in_data;
                            valid_d[in_sel] = 1'b1;
                            if (!valid_q[in_sel]) begin
                                count_d = count_q + C_ONE;
                            end
                        end else begin
                            wr_drop_d = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    wr_drop_d = w_enable;
                    if (advance) begin
                        if (cur_valid) begin
                            valid_d[ptr_q] = 1'b0;
                            count_d        = count_q - C_ONE;
                        end
                        if (ptr_q == LAST) begin
                            state_d = IDLE;
                            ptr_d   = '0;
                        end else begin
                            ptr_d = ptr_q + P_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            data_q    <= '{default: '0};
            valid_q   <= '0;
            count_q   <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    assign out_data    = out_ok ? data_q[out_sel] : '0;
    assign out_valid   = out_ok && valid_q[out_sel];
    assign drain_valid = draining && cur_valid;
    assign drain_data  = drain_valid ? data_q[ptr_q] : '0;
    assign drain_idx   = drain_valid ? ptr_q : '0;
    assign drain_busy  = draining;
    assign count       = count_q;
    assign wr_drop     = wr_drop_q;

endmodule

// File: tb/tb_result_bank.sv
// Directed bench for result_bank: rule-level bank model checked every
// cycle, plus literal expectations on the key scenarios.
module tb_result_bank;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_enable = 1'b0;
    logic [AW-1:0] in_sel = '0;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] out_sel = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          clear_data = 1'b0;
    logic          drain_start = 1'b0;
    logic          drain_valid;
    logic          drain_ready = 1'b0;
    logic [W-1:0]  drain_data;
    logic [AW-1:0] drain_idx;
    logic          drain_busy;
    logic [AW:0]   count;
    logic          wr_drop;

    result_bank #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .w_enable(w_enable), .in_sel(in_sel), .in_data(in_data),
        .out_sel(out_sel), .out_data(out_data), .out_valid(out_valid),
        .clear_data(clear_data), .drain_start(drain_start),
        .drain_valid(drain_valid), .drain_ready(drain_ready),
        .drain_data(drain_data), .drain_idx(drain_idx),
        .drain_busy(drain_busy), .count(count), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Bank model: contents, drain pointer and the handshake log
    logic [W-1:0] mdata [D];
    bit           mvalid [D];
    bit           mdrain;
    int           mptr;
    int           mcount;
    bit           mdrop;
    bit           armed = 1'b0;
    int           hs_idx [$];
    int           hs_data [$];

    task automatic model_zero();
        for (int i = 0; i < D; i++) begin
            mdata[i]  = '0;
            mvalid[i] = 1'b0;
        end
        mdrain = 1'b0;
        mptr   = 0;
        mcount = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_zero();
            mdrop = 1'b0;
        end else if (clear_data) begin
            model_zero();
            mdrop = w_enable;
        end else if (!mdrain) begin
            mdrop = 1'b0;
            if (drain_start) begin
                mdrain = 1'b1;
                mptr   = 0;
                mdrop  = w_enable;
            end else if (w_enable) begin
                if (!mvalid[in_sel]) mcount++;
                mvalid[in_sel] = 1'b1;
                mdata[in_sel]  = in_data;
            end
        end else begin
            mdrop = w_enable;
            if (mvalid[mptr] && drain_ready) begin
                hs_idx.push_back(mptr);
                hs_data.push_back(int'(mdata[mptr]));
                mvalid[mptr] = 1'b0;
                mcount--;
            end
            if (!mvalid[mptr]) begin
                if (mptr == D - 1) begin
                    mdrain = 1'b0;
                    mptr   = 0;
                end else begin
                    mptr++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            automatic bit dv = mdrain && mvalid[mptr];
            chk("out_data", 64'(out_data), 64'(mdata[out_sel]));
            chk("out_valid", 64'(out_valid), 64'(mvalid[out_sel]));
            chk("count", 64'(count), 64'(mcount));
            chk("drain_busy", 64'(drain_busy), 64'(mdrain));
            chk("drain_valid", 64'(drain_valid), 64'(dv));
            chk("drain_data", 64'(drain_data), dv ? 64'(mdata[mptr]) : 64'd0);
            chk("drain_idx", 64'(drain_idx), dv ? 64'(mptr) : 64'd0);
            chk("wr_drop", 64'(wr_drop), 64'(mdrop));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        armed = 1'b1;
        #1;
    endtask

    task automatic wr(input int idx, input int val);
        w_enable = 1'b1;
        in_sel   = AW'(idx);
        in_data  = W'(val);
        tick();
        w_enable = 1'b0;
    endtask

    task automatic finish_drain(output int cyc);
        cyc = 0;
        while (drain_busy && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic start_drain();
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
    endtask

    initial begin
        int n;
        mdrop = 1'b0;
        model_zero();
        tick();
        tick();
        chk("rst_busy", 64'(drain_busy), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        rst = 1'b0;

        wr(3, 'hA5A5);
        out_sel = 4'd3;
        #1;
        chk("w3_data", 64'(out_data), 64'hA5A5);
        chk("w3_valid", 64'(out_valid), 64'd1);
        chk("w3_count", 64'(count), 64'd1);
        out_sel = 4'd4;
        #1;
        chk("r4_data", 64'(out_data), 64'h0);
        chk("r4_valid", 64'(out_valid), 64'd0);

        clear_data = 1'b1;
        tick();
        clear_data = 1'b0;
        wr(2, 'h1111);
        wr(9, 'h2222);
        hs_idx.delete();
        hs_data.delete();
        drain_ready = 1'b1;
        start_drain();
        finish_drain(n);
        chk("busy_cycles", 64'(n), 64'd16);
        chk("hs_count", 64'(hs_idx.size()), 64'd2);
        if (hs_idx.size() == 2) begin
            chk("hs0_idx", 64'(hs_idx[0]), 64'd2);
            chk("hs1_idx", 64'(hs_idx[1]), 64'd9);
            chk("hs1_data", 64'(hs_data[1]), 64'h2222);
        end
        chk("drain_count", 64'(count), 64'd0);

        wr(2, 'h1111);
        wr(9, 'h2222);
        drain_ready = 1'b0;
        start_drain();
        n = 0;
        while (!drain_valid && n < 20) begin
            tick();
            n++;
        end
        chk("reach_idx2", 64'(n), 64'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 64'(drain_valid), 64'd1);
            chk("stall_data", 64'(drain_data), 64'h1111);
            chk("stall_idx", 64'(drain_idx), 64'd2);
        end
        drain_ready = 1'b1;
        finish_drain(n);
        chk("stall_busy", 64'(drain_busy), 64'd0);
        chk("stall_count", 64'(count), 64'd0);

        wr(5, 'h0001);
        wr(5, 'hBEEF);
        out_sel = 4'd5;
        #1;
        chk("rw_count", 64'(count), 64'd1);
        chk("rw_data", 64'(out_data), 64'hBEEF);
        drain_ready = 1'b0;
        start_drain();
        wr(6, 'h1234);
        chk("drop_pulse", 64'(wr_drop), 64'd1);
        out_sel = 4'd6;
        tick();
        chk("drop_once", 64'(wr_drop), 64'd0);
        chk("drop_nowrite", 64'(out_valid), 64'd0);
        drain_ready = 1'b1;
        finish_drain(n);

        w_enable    = 1'b1;
        drain_start = 1'b1;
        in_sel      = 4'd0;
        in_data     = 16'h5555;
        tick();
        w_enable    = 1'b0;
        drain_start = 1'b0;
        chk("start_drop", 64'(wr_drop), 64'd1);
        finish_drain(n);
        chk("empty_cycles", 64'(n), 64'd16);

        wr(1, 'h0101);
        wr(4, 'h0404);
        wr(7, 'h0707);
        wr(12, 'h0C0C);
        chk("four_count", 64'(count), 64'd4);
        start_drain();
        tick();
        tick();
        clear_data = 1'b1;
        w_enable   = 1'b1;
        tick();
        clear_data = 1'b0;
        w_enable   = 1'b0;
        chk("clr_busy", 64'(drain_busy), 64'd0);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_drop", 64'(wr_drop), 64'd1);
        for (int i = 0; i < D; i++) begin
            out_sel = AW'(i);
            #1;
            chk("clr_valid", 64'(out_valid), 64'd0);
            tick();
        end

        wr(1, 'h0101);
        wr(4, 'h0404);
        wr(7, 'h0707);
        wr(12, 'h0C0C);
        start_drain();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrst_busy", 64'(drain_busy), 64'd0);
        chk("rrst_count", 64'(count), 64'd0);
        chk("rrst_dvalid", 64'(drain_valid), 64'd0);
        for (int i = 0; i < D; i++) begin
            out_sel = AW'(i);
            #1;
            chk("rrst_data", 64'(out_data), 64'd0);
            tick();
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
